ram_burst_decoder: RTL and testbench
====================================

RAM_BURST_DECODER -- requirements
Module: ram_burst_decoder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: number of non-latch RAM clock posedges between the address latch and the first data word.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, at least 2.
REQ-003 Parameter READ_ON_NEGEDGE, default 0: when 1, read data is taken from the negative-edge sampler instead of the positive-edge one.
REQ-004 mclk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low (asserted at 0); clears all state immediately.
REQ-006 filter_a  in  23  filtered address bus.
REQ-007 filter_d  in  16  filtered data, posedge sample.
REQ-008 filter_ublb  in  2  byte enables {upper, lower}, positive logic.
REQ-009 filter_read / filter_write / filter_addr_latch  in  1 each  positive-logic control, chip-enable qualified.
REQ-010 filter_strobe  in  1  one-cycle pulse; filter_* valid for one RAM clock posedge.
REQ-011 nfilter_d  in  16  filtered data, negedge sample.
REQ-012 nfilter_strobe  in  1  one-cycle pulse; nfilter_d updated; never coincident with filter_strobe.
REQ-013 out_valid  out  1  FIFO head valid.
REQ-014 out_ready  in  1  consumer accepts head when high with out_valid.
REQ-015 out_addr  out  23  word address of the head entry.
REQ-016 out_data  out  16  word data.
REQ-017 out_ublb  out  2  byte enables of the word.
REQ-018 out_write  out  1  1 = write, 0 = read.
REQ-019 out_first  out  1  first word after an address latch.
REQ-020 overflow  out  1  sticky: a word was discarded.

Function
REQ-021 States IDLE, WAIT, BURST; only filter_strobe cycles advance the FSM, except for the negedge capture in REQ-027.
REQ-022 Any state, strobe with filter_addr_latch=1: base_addr <= filter_a, wait_cnt <= WAIT_CYCLES, first <= 1, pending read cleared; next state is WAIT, or BURST if WAIT_CYCLES = 0. This rule takes priority over all others.
REQ-023 WAIT, strobe without latch: wait_cnt decrements; on the strobe that makes it 0, go to BURST. No word is emitted during WAIT.
REQ-024 BURST, strobe with read or write and no latch: emit word {base_addr, data, filter_ublb, filter_write, first}; then base_addr <= base_addr + 1 modulo 2^23 (0x7FFFFF wraps to 0), and first <= 0.
REQ-025 BURST, strobe with read, write and latch all 0: go to IDLE with no emission.
REQ-026 Emitted data is filter_d for writes, and for reads when READ_ON_NEGEDGE=0.
REQ-027 READ_ON_NEGEDGE=1, read in BURST: the word is held pending and is pushed with nfilter_d at the next nfilter_strobe.
REQ-028 If a filter_strobe arrives while a read is still pending, the pending word is discarded, overflow is set, and the new strobe is processed normally.
REQ-029 Push occurs on the mclk edge that samples the strobe (filter or nfilter); out_valid rises on the following cycle when the FIFO was empty.
REQ-030 Pop occurs when out_valid && out_ready; out_* present the head entry combinationally from FIFO storage and hold stable while out_valid && !out_ready.
REQ-031 Push when full and no pop in the same cycle: the word is discarded, FIFO is unchanged, overflow <= 1.
REQ-032 Push when full with a pop in the same cycle: both take effect and occupancy is unchanged.
REQ-033 Push and pop when the FIFO is empty: the push is stored and out_valid rises next cycle.
REQ-034 Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full and empty are derived from the pointer MSB and the lower bits.
REQ-035 overflow clears only on reset.

Reset
REQ-036 While reset=0: state=IDLE, base_addr=0, wait_cnt=0, first=0, pending cleared, FIFO empty, out_valid=0, out_addr=0, out_data=0, out_ublb=0, out_write=0, out_first=0, overflow=0.
REQ-037 Reset asserted mid-burst discards all queued and pending words; the first strobe after release is evaluated from IDLE.

Verification
REQ-038 Scenario, basic burst: WAIT_CYCLES=2; latch at 0x000100, 2 idle strobes, then 3 read strobes with filter_d 0xAAAA, 0xBBBB, 0xCCCC and out_ready=1 -> 3 words at addresses 0x100, 0x101, 0x102 with those data values; out_first=1 on the first word only.
REQ-039 Scenario, wrap: latch at 0x7FFFFF, 2 write strobes -> words at addresses 0x7FFFFF, then 0x000000; out_write=1.
REQ-040 Scenario, overflow: out_ready=0, 5 words into a FIFO_DEPTH=4 FIFO -> 4 words retained (addresses 0 through 3), overflow=1; after draining, out_valid=0 and overflow stays 1.
REQ-041 Scenario, negedge read: READ_ON_NEGEDGE=1; read strobe, then nfilter_strobe with nfilter_d=0x1234 -> one word with data 0x1234, pushed on the nfilter_strobe edge; read then second read with no nfilter_strobe between -> first word dropped, overflow=1.
REQ-042 Scenario, re-latch mid-burst: burst at 0x200, 1 word, then latch at 0x300 -> WAIT restarts; the next emitted word is at address 0x300 with out_first=1.
REQ-043 Scenario, async reset: reset asserted with 2 words queued -> out_valid=0 immediately without a clock edge; after release, the FSM is IDLE and the FIFO is empty.

Source files
------------

// File: rtl/ram_burst_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_decoder
// Brief    : Turns filtered RAM bus strobes into addressed burst words
//            queued in a small output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst_decoder #(
    parameter int WAIT_CYCLES     = 2,
    parameter int FIFO_DEPTH      = 4,
    parameter int READ_ON_NEGEDGE = 0
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic [22:0] filter_a,
    input  logic [15:0] filter_d,
    input  logic [1:0]  filter_ublb,
    input  logic        filter_read,
    input  logic        filter_write,
    input  logic        filter_addr_latch,
    input  logic        filter_strobe,
    input  logic [15:0] nfilter_d,
    input  logic        nfilter_strobe,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [22:0] out_addr,
    output logic [15:0] out_data,
    output logic [1:0]  out_ublb,
    output logic        out_write,
    output logic        out_first,
    output logic        overflow
);

    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_PW     = c_AW + 1;
    localparam int c_WCW    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int c_WORD_W = 43;
    localparam logic [c_WCW-1:0] c_WAIT_INIT = c_WCW'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [22:0]         r_base, w_base_nxt;
    logic [c_WCW-1:0]    r_wait, w_wait_nxt;
    logic                r_first, w_first_nxt;
    logic                r_pend_valid, w_pend_valid_nxt;
    logic [25:0]         r_pend_info, w_pend_info_nxt;   // {addr, ublb, first}
    logic                r_overflow;

    logic                w_push;
    logic [c_WORD_W-1:0] w_push_word;
    logic                w_pend_drop;

    logic [c_PW-1:0]     r_wptr, r_rptr;
    logic [c_WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic                w_empty, w_full, w_pop, w_wr_en, w_push_lost;
    logic [c_WORD_W-1:0] w_head;

    always_comb begin
        w_state_nxt      = r_state;
        w_base_nxt       = r_base;
        w_wait_nxt       = r_wait;
        w_first_nxt      = r_first;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_info_nxt  = r_pend_info;
        w_push           = 1'b0;
        w_push_word      = '0;
        w_pend_drop      = 1'b0;

        if (filter_strobe) begin
            // A pending negedge read that never got its data is lost.
            w_pend_drop      = r_pend_valid;
            w_pend_valid_nxt = 1'b0;
            if (filter_addr_latch) begin
                w_base_nxt  = filter_a;
                w_wait_nxt  = c_WAIT_INIT;
                w_first_nxt = 1'b1;
                w_state_nxt = (WAIT_CYCLES == 0) ? S_BURST : S_WAIT;
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (r_wait != '0) begin
                            w_wait_nxt = r_wait - c_WCW'(1);
                        end
                        if (r_wait <= c_WCW'(1)) begin
                            w_state_nxt = S_BURST;
                        end
                    end
                    S_BURST: begin
                        if (filter_read || filter_write) begin
                            if (filter_write || (READ_ON_NEGEDGE == 0)) begin
                                w_push      = 1'b1;
                                w_push_word = {r_base, filter_d, filter_ublb, filter_write, r_first};
                            end else begin
                                w_pend_valid_nxt = 1'b1;
                                w_pend_info_nxt  = {r_base, filter_ublb, r_first};
                            end
                            w_base_nxt  = r_base + 23'd1;
                            w_first_nxt = 1'b0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (nfilter_strobe && r_pend_valid) begin
            w_push           = 1'b1;
            w_push_word      = {r_pend_info[25:3], nfilter_d, r_pend_info[2:1], 1'b0, r_pend_info[0]};
            w_pend_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_base       <= '0;
            r_wait       <= '0;
            r_first      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_info  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_base       <= w_base_nxt;
            r_wait       <= w_wait_nxt;
            r_first      <= w_first_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_info  <= w_pend_info_nxt;
        end
    end

    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                         (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_pop       = !w_empty && out_ready;
    assign w_wr_en     = w_push && (!w_full || w_pop);
    assign w_push_lost = w_push && w_full && !w_pop;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            if (w_pend_drop || w_push_lost) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[c_AW-1:0]] <= w_push_word;
        end
    end

    // Outputs read zero whenever the FIFO is empty, including during reset.
    assign w_head    = w_empty ? '0 : r_mem[r_rptr[c_AW-1:0]];
    assign out_valid = !w_empty;
    assign out_addr  = w_head[42:20];
    assign out_data  = w_head[19:4];
    assign out_ublb  = w_head[3:2];
    assign out_write = w_head[1];
    assign out_first = w_head[0];
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_burst_decoder
// Brief    : Self-checking bench for ram_burst_decoder (posedge and negedge
//            read variants side by side on shared stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_burst_decoder;

    typedef struct packed {
        logic [22:0] a;
        logic [15:0] d;
        logic [1:0]  ub;
        logic        w;
        logic        f;
    } word_t;

    logic        mclk, reset;
    logic [22:0] filter_a;
    logic [15:0] filter_d, nfilter_d;
    logic [1:0]  filter_ublb;
    logic        filter_read, filter_write, filter_addr_latch, filter_strobe, nfilter_strobe;
    logic        out_ready;

    logic        o0_valid, o0_write, o0_first, o0_ovf;
    logic [22:0] o0_addr;
    logic [15:0] o0_data;
    logic [1:0]  o0_ublb;
    logic        o1_valid, o1_write, o1_first, o1_ovf;
    logic [22:0] o1_addr;
    logic [15:0] o1_data;
    logic [1:0]  o1_ublb;

    int    n_tests = 0;
    int    n_fails = 0;
    word_t obs0[$];
    word_t obs1[$];

    ram_burst_decoder #(.WAIT_CYCLES(2), .FIFO_DEPTH(4), .READ_ON_NEGEDGE(0)) dut0 (
        .mclk(mclk), .reset(reset), .filter_a(filter_a), .filter_d(filter_d),
        .filter_ublb(filter_ublb), .filter_read(filter_read), .filter_write(filter_write),
        .filter_addr_latch(filter_addr_latch), .filter_strobe(filter_strobe),
        .nfilter_d(nfilter_d), .nfilter_strobe(nfilter_strobe),
        .out_valid(o0_valid), .out_ready(out_ready), .out_addr(o0_addr), .out_data(o0_data),
        .out_ublb(o0_ublb), .out_write(o0_write), .out_first(o0_first), .overflow(o0_ovf)
    );

    ram_burst_decoder #(.WAIT_CYCLES(2), .FIFO_DEPTH(4), .READ_ON_NEGEDGE(1)) dut1 (
        .mclk(mclk), .reset(reset), .filter_a(filter_a), .filter_d(filter_d),
        .filter_ublb(filter_ublb), .filter_read(filter_read), .filter_write(filter_write),
        .filter_addr_latch(filter_addr_latch), .filter_strobe(filter_strobe),
        .nfilter_d(nfilter_d), .nfilter_strobe(nfilter_strobe),
        .out_valid(o1_valid), .out_ready(out_ready), .out_addr(o1_addr), .out_data(o1_data),
        .out_ublb(o1_ublb), .out_write(o1_write), .out_first(o1_first), .overflow(o1_ovf)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Record every accepted word, sampled mid-cycle ahead of the popping edge.
    always @(negedge mclk) begin
        if (reset && o0_valid && out_ready) obs0.push_back({o0_addr, o0_data, o0_ublb, o0_write, o0_first});
        if (reset && o1_valid && out_ready) obs1.push_back({o1_addr, o1_data, o1_ublb, o1_write, o1_first});
    end

    function automatic word_t mk(input logic [22:0] a, input logic [15:0] d,
                                 input logic [1:0] ub, input logic w, input logic f);
        word_t x;
        x.a = a; x.d = d; x.ub = ub; x.w = w; x.f = f;
        return x;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic strobe(input logic [22:0] a, input logic [15:0] d, input logic [1:0] ub,
                          input logic rd, input logic wr, input logic la);
        @(posedge mclk); #1;
        filter_a = a; filter_d = d; filter_ublb = ub;
        filter_read = rd; filter_write = wr; filter_addr_latch = la; filter_strobe = 1'b1;
        @(posedge mclk); #1;
        filter_strobe = 1'b0; filter_read = 1'b0; filter_write = 1'b0; filter_addr_latch = 1'b0;
    endtask

    task automatic nstrobe(input logic [15:0] d);
        @(posedge mclk); #1;
        nfilter_d = d; nfilter_strobe = 1'b1;
        @(posedge mclk); #1;
        nfilter_strobe = 1'b0;
    endtask

    task automatic latch_and_wait(input logic [22:0] a);
        strobe(a, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1);
        strobe(23'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        strobe(23'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic end_burst();
        strobe(23'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycles(2);
        reset = 1'b1;
        obs0.delete();
        obs1.delete();
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if ({o0_valid, o0_addr, o0_data, o0_ublb, o0_write, o0_first, o0_ovf} !== 46'h0) begin
            n_fails++;
            $display("FAIL reset_outputs_dut0: got %h expected 0",
                     {o0_valid, o0_addr, o0_data, o0_ublb, o0_write, o0_first, o0_ovf});
        end
        n_tests++;
        if ({o1_valid, o1_addr, o1_data, o1_ublb, o1_write, o1_first, o1_ovf} !== 46'h0) begin
            n_fails++;
            $display("FAIL reset_outputs_dut1: got %h expected 0",
                     {o1_valid, o1_addr, o1_data, o1_ublb, o1_write, o1_first, o1_ovf});
        end
    endtask

    task automatic test_basic_burst();
        word_t exp[$];
        do_reset();
        out_ready = 1'b1;
        latch_and_wait(23'h000100);
        strobe(23'h0, 16'hAAAA, 2'b11, 1'b1, 1'b0, 1'b0);
        strobe(23'h0, 16'hBBBB, 2'b11, 1'b1, 1'b0, 1'b0);
        strobe(23'h0, 16'hCCCC, 2'b11, 1'b1, 1'b0, 1'b0);
        end_burst();
        cycles(4);
        exp.push_back(mk(23'h100, 16'hAAAA, 2'b11, 1'b0, 1'b1));
        exp.push_back(mk(23'h101, 16'hBBBB, 2'b11, 1'b0, 1'b0));
        exp.push_back(mk(23'h102, 16'hCCCC, 2'b11, 1'b0, 1'b0));
        n_tests++;
        if (obs0.size() != exp.size()) begin
            n_fails++;
            $display("FAIL basic_count: got %0d expected %0d", obs0.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_tests++;
            if (i >= obs0.size() || obs0[i] !== exp[i]) begin
                n_fails++;
                $display("FAIL basic_word%0d: got %h expected %h", i, obs0[i], exp[i]);
            end
        end
        // Negedge variant: each read is abandoned by the next strobe.
        n_tests++;
        if (obs1.size() != 0 || o1_ovf !== 1'b1) begin
            n_fails++;
            $display("FAIL basic_negedge_drop: got words=%0d ovf=%b expected words=0 ovf=1", obs1.size(), o1_ovf);
        end
    endtask

    task automatic test_wrap();
        word_t exp[$];
        do_reset();
        out_ready = 1'b1;
        latch_and_wait(23'h7FFFFF);
        strobe(23'h0, 16'h1111, 2'b01, 1'b0, 1'b1, 1'b0);
        strobe(23'h0, 16'h2222, 2'b10, 1'b0, 1'b1, 1'b0);
        end_burst();
        cycles(4);
        exp.push_back(mk(23'h7FFFFF, 16'h1111, 2'b01, 1'b1, 1'b1));
        exp.push_back(mk(23'h000000, 16'h2222, 2'b10, 1'b1, 1'b0));
        n_tests++;
        if (obs0.size() != 2 || obs1.size() != 2) begin
            n_fails++;
            $display("FAIL wrap_count: got %0d/%0d expected 2/2", obs0.size(), obs1.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (i >= obs0.size() || i >= obs1.size() || obs0[i] !== exp[i] || obs1[i] !== exp[i]) begin
                n_fails++;
                $display("FAIL wrap_word%0d: got %h/%h expected %h", i, obs0[i], obs1[i], exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        latch_and_wait(23'h000000);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                n_tests++;
                if (o0_ovf !== 1'b0) begin
                    n_fails++;
                    $display("FAIL ovf_before_full: got %b expected 0", o0_ovf);
                end
            end
            strobe(23'h0, 16'h5000 + 16'(i), 2'b11, 1'b0, 1'b1, 1'b0);
        end
        end_burst();
        cycles(2);
        n_tests++;
        if (o0_ovf !== 1'b1 || o0_valid !== 1'b1 || o0_addr !== 23'h0 || o0_first !== 1'b1) begin
            n_fails++;
            $display("FAIL ovf_full_head: got ovf=%b valid=%b addr=%h first=%b expected 1 1 000000 1",
                     o0_ovf, o0_valid, o0_addr, o0_first);
        end
        out_ready = 1'b1;
        cycles(8);
        n_tests++;
        if (obs0.size() != 4) begin
            n_fails++;
            $display("FAIL ovf_count: got %0d expected 4", obs0.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (i >= obs0.size() || obs0[i] !== mk(23'(i), 16'h5000 + 16'(i), 2'b11, 1'b1, i == 0)) begin
                n_fails++;
                $display("FAIL ovf_word%0d: got %h expected %h", i, obs0[i],
                         mk(23'(i), 16'h5000 + 16'(i), 2'b11, 1'b1, i == 0));
            end
        end
        n_tests++;
        if (o0_valid !== 1'b0 || o0_ovf !== 1'b1) begin
            n_fails++;
            $display("FAIL ovf_after_drain: got valid=%b ovf=%b expected 0 1", o0_valid, o0_ovf);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        out_ready = 1'b0;
        latch_and_wait(23'h000010);
        for (int i = 0; i < 4; i++) strobe(23'h0, 16'h6000 + 16'(i), 2'b11, 1'b0, 1'b1, 1'b0);
        @(posedge mclk); #1;
        filter_d = 16'h6004; filter_ublb = 2'b11; filter_write = 1'b1; filter_strobe = 1'b1;
        out_ready = 1'b1;
        @(posedge mclk); #1;
        filter_strobe = 1'b0; filter_write = 1'b0; out_ready = 1'b0;
        n_tests++;
        if (o0_ovf !== 1'b0 || o0_valid !== 1'b1 || o0_addr !== 23'h11) begin
            n_fails++;
            $display("FAIL fullpp_state: got ovf=%b valid=%b addr=%h expected 0 1 000011", o0_ovf, o0_valid, o0_addr);
        end
        out_ready = 1'b1;
        cycles(8);
        n_tests++;
        if (obs0.size() != 5) begin
            n_fails++;
            $display("FAIL fullpp_count: got %0d expected 5", obs0.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (i >= obs0.size() || obs0[i] !== mk(23'h10 + 23'(i), 16'h6000 + 16'(i), 2'b11, 1'b1, i == 0)) begin
                n_fails++;
                $display("FAIL fullpp_word%0d: got %h expected %h", i, obs0[i],
                         mk(23'h10 + 23'(i), 16'h6000 + 16'(i), 2'b11, 1'b1, i == 0));
            end
        end
    endtask

    task automatic test_relatch();
        word_t exp[$];
        do_reset();
        out_ready = 1'b1;
        latch_and_wait(23'h000200);
        strobe(23'h0, 16'hD001, 2'b11, 1'b1, 1'b0, 1'b0);
        strobe(23'h000300, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1);
        strobe(23'h0, 16'hEEEE, 2'b11, 1'b1, 1'b0, 1'b0);   // consumed by the wait
        strobe(23'h0, 16'hEEEE, 2'b11, 1'b1, 1'b0, 1'b0);
        strobe(23'h0, 16'hD002, 2'b11, 1'b1, 1'b0, 1'b0);
        end_burst();
        cycles(4);
        exp.push_back(mk(23'h200, 16'hD001, 2'b11, 1'b0, 1'b1));
        exp.push_back(mk(23'h300, 16'hD002, 2'b11, 1'b0, 1'b1));
        n_tests++;
        if (obs0.size() != 2) begin
            n_fails++;
            $display("FAIL relatch_count: got %0d expected 2", obs0.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (i >= obs0.size() || obs0[i] !== exp[i]) begin
                n_fails++;
                $display("FAIL relatch_word%0d: got %h expected %h", i, obs0[i], exp[i]);
            end
        end
    endtask

    task automatic test_negedge();
        word_t exp[$];
        do_reset();
        out_ready = 1'b0;
        latch_and_wait(23'h000040);
        strobe(23'h0, 16'hFFFF, 2'b01, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (o1_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL neg_not_on_read: got valid=%b expected 0", o1_valid);
        end
        nstrobe(16'h1234);
        n_tests++;
        if (o1_valid !== 1'b1 || {o1_addr, o1_data, o1_ublb, o1_write, o1_first} !== mk(23'h40, 16'h1234, 2'b01, 1'b0, 1'b1)) begin
            n_fails++;
            $display("FAIL neg_head: got valid=%b word=%h expected 1 %h", o1_valid,
                     {o1_addr, o1_data, o1_ublb, o1_write, o1_first}, mk(23'h40, 16'h1234, 2'b01, 1'b0, 1'b1));
        end
        n_tests++;
        if ({o0_addr, o0_data, o0_ublb, o0_write, o0_first} !== mk(23'h40, 16'hFFFF, 2'b01, 1'b0, 1'b1)) begin
            n_fails++;
            $display("FAIL pos_read_head: got %h expected %h",
                     {o0_addr, o0_data, o0_ublb, o0_write, o0_first}, mk(23'h40, 16'hFFFF, 2'b01, 1'b0, 1'b1));
        end
        out_ready = 1'b1;
        cycles(3);
        strobe(23'h0, 16'h0, 2'b10, 1'b1, 1'b0, 1'b0);
        strobe(23'h0, 16'h0, 2'b10, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (o1_ovf !== 1'b1 || o0_ovf !== 1'b0) begin
            n_fails++;
            $display("FAIL neg_drop_ovf: got %b/%b expected 1/0", o1_ovf, o0_ovf);
        end
        nstrobe(16'h5678);
        end_burst();
        cycles(4);
        exp.push_back(mk(23'h40, 16'h1234, 2'b01, 1'b0, 1'b1));
        exp.push_back(mk(23'h42, 16'h5678, 2'b10, 1'b0, 1'b0));
        n_tests++;
        if (obs1.size() != 2) begin
            n_fails++;
            $display("FAIL neg_count: got %0d expected 2", obs1.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (i >= obs1.size() || obs1[i] !== exp[i]) begin
                n_fails++;
                $display("FAIL neg_word%0d: got %h expected %h", i, obs1[i], exp[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        latch_and_wait(23'h000500);
        strobe(23'h0, 16'h0101, 2'b11, 1'b0, 1'b1, 1'b0);
        strobe(23'h0, 16'h0202, 2'b11, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (o0_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL areset_queued: got valid=%b expected 1", o0_valid);
        end
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (o0_valid !== 1'b0 || o1_valid !== 1'b0 || o0_addr !== 23'h0) begin
            n_fails++;
            $display("FAIL areset_immediate: got valid=%b/%b addr=%h expected 0/0 000000", o0_valid, o1_valid, o0_addr);
        end
        cycles(1);
        reset = 1'b1;
        obs0.delete();
        obs1.delete();
        out_ready = 1'b1;
        strobe(23'h0, 16'h0303, 2'b11, 1'b1, 1'b0, 1'b0);
        strobe(23'h0, 16'h0404, 2'b11, 1'b0, 1'b1, 1'b0);
        cycles(3);
        n_tests++;
        if (obs0.size() != 0 || o0_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL areset_idle: got words=%0d valid=%b expected 0 0", obs0.size(), o0_valid);
        end
        latch_and_wait(23'h000600);
        strobe(23'h0, 16'h7777, 2'b11, 1'b0, 1'b1, 1'b0);
        cycles(3);
        n_tests++;
        if (obs0.size() != 1 || obs0[0] !== mk(23'h600, 16'h7777, 2'b11, 1'b1, 1'b1)) begin
            n_fails++;
            $display("FAIL areset_recover: got %0d words head %h expected 1 %h", obs0.size(), obs0[0],
                     mk(23'h600, 16'h7777, 2'b11, 1'b1, 1'b1));
        end
    endtask

    task automatic test_random();
        do_reset();
        out_ready = 1'b1;
        for (int it = 0; it < 8; it++) begin
            word_t       exp[$];
            logic [22:0] base;
            int          n;
            logic        rd, wr;
            logic [15:0] d;
            logic [1:0]  ub;
            base = (it == 0) ? 23'h7FFFFD : 23'($urandom);
            n    = $urandom_range(1, 6);
            // A data strobe outside a burst must be ignored.
            strobe(23'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            strobe(base, 16'h0, 2'b00, 1'b0, 1'b0, 1'b1);
            strobe(23'h0, 16'($urandom), 2'b11, 1'($urandom), 1'($urandom), 1'b0);
            strobe(23'h0, 16'($urandom), 2'b11, 1'($urandom), 1'($urandom), 1'b0);
            for (int i = 0; i < n; i++) begin
                rd = 1'($urandom);
                wr = rd ? 1'($urandom) : 1'b1;
                d  = 16'($urandom);
                ub = 2'($urandom);
                strobe(23'($urandom), d, ub, rd, wr, 1'b0);
                exp.push_back(mk(base + 23'(i), d, ub, wr, i == 0));
            end
            end_burst();
            cycles(4);
            n_tests++;
            if (obs0.size() != exp.size()) begin
                n_fails++;
                $display("FAIL rand%0d_count: got %0d expected %0d", it, obs0.size(), exp.size());
            end
            for (int i = 0; i < exp.size(); i++) begin
                n_tests++;
                if (i >= obs0.size() || obs0[i] !== exp[i]) begin
                    n_fails++;
                    $display("FAIL rand%0d_word%0d: got %h expected %h", it, i, obs0[i], exp[i]);
                end
            end
            obs0.delete();
            obs1.delete();
        end
    endtask

    initial begin
        reset = 1'b0;
        filter_a = '0; filter_d = '0; filter_ublb = '0;
        filter_read = 1'b0; filter_write = 1'b0; filter_addr_latch = 1'b0; filter_strobe = 1'b0;
        nfilter_d = '0; nfilter_strobe = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic_burst();
        test_wrap();
        test_overflow();
        test_full_push_pop();
        test_relatch();
        test_negedge();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
